mux21_sel_arb: RTL and testbench

Two-requester round-robin arbiter that drives the select line of the downstream 2:1 data mux. It grants one of two sources (A, B), holds the grant for a packet or up to a bounded number of cycles, and outputs a registered select `s` (0 = A, 1 = B) plus per-source grants. It sits directly upstream of the 2:1 mux, and `s` connects straight to that mux's select input.

---
 rtl/mux21_sel_arb_if.sv | 22 ++
 rtl/mux21_sel_arb.sv | 124 ++++++++++++
 tb/tb_mux21_sel_arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mux21_sel_arb_if.sv
// Handshake bundle between the two requesters and the 2:1 mux select arbiter.
// The arbiter takes the slave side. The requesters, or the bench, take the master side.
interface mux21_sel_arb_if;
  logic req_a;
  logic req_b;
  logic last_a;
  logic last_b;
  logic s;
  logic gnt_a;
  logic gnt_b;
  logic busy;

  modport master (
    output req_a, req_b, last_a, last_b,
    input  s, gnt_a, gnt_b, busy
  );

  modport slave (
    input  req_a, req_b, last_a, last_b,
    output s, gnt_a, gnt_b, busy
  );
endinterface

// File: rtl/mux21_sel_arb.sv
// Two-source round-robin arbiter driving the select of a downstream 2:1 mux.
// Grants are held per packet and preempted after MAX_HOLD cycles under contention.
module mux21_sel_arb #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  mux21_sel_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_prio;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_s;
  logic                r_gnt_a;
  logic                r_gnt_b;
  logic                r_busy;
  logic                w_hold_max;
  logic                w_rel_a;
  logic                w_rel_b;

  assign w_hold_max = (r_hold == HOLD_W'(MAX_HOLD));
  assign w_rel_a    = bus.last_a | ~bus.req_a | (w_hold_max & bus.req_b);
  assign w_rel_b    = bus.last_b | ~bus.req_b | (w_hold_max & bus.req_a);

  // Next-state selection; a release hands over directly when the other side waits
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_a && bus.req_b) begin
          w_next = r_prio ? OWN_B : OWN_A;
        end else if (bus.req_a) begin
          w_next = OWN_A;
        end else if (bus.req_b) begin
          w_next = OWN_B;
        end else begin
          w_next = IDLE;
        end
      end
      OWN_A: begin
        if (w_rel_a) begin
          w_next = bus.req_b ? OWN_B : IDLE;
        end else begin
          w_next = OWN_A;
        end
      end
      OWN_B: begin
        if (w_rel_b) begin
          w_next = bus.req_a ? OWN_A : IDLE;
        end else begin
          w_next = OWN_B;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State, priority, hold counter and all outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
      r_hold  <= '0;
      r_s     <= 1'b0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (w_next)
        OWN_A: begin
          r_gnt_a <= 1'b1;
          r_gnt_b <= 1'b0;
          r_busy  <= 1'b1;
          r_s     <= 1'b0;
          if (r_state != OWN_A) begin
            r_hold <= HOLD_W'(1);
            r_prio <= 1'b1;
          end else if (!w_hold_max) begin
            r_hold <= r_hold + HOLD_W'(1);
          end else begin
            r_hold <= r_hold;
          end
        end
        OWN_B: begin
          r_gnt_a <= 1'b0;
          r_gnt_b <= 1'b1;
          r_busy  <= 1'b1;
          r_s     <= 1'b1;
          if (r_state != OWN_B) begin
            r_hold <= HOLD_W'(1);
            r_prio <= 1'b0;
          end else if (!w_hold_max) begin
            r_hold <= r_hold + HOLD_W'(1);
          end else begin
            r_hold <= r_hold;
          end
        end
        default: begin
          // s is left alone so the mux output does not glitch while idle
          r_gnt_a <= 1'b0;
          r_gnt_b <= 1'b0;
          r_busy  <= 1'b0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  assign bus.s     = r_s;
  assign bus.gnt_a = r_gnt_a;
  assign bus.gnt_b = r_gnt_b;
  assign bus.busy  = r_busy;

endmodule

// File: tb/tb_mux21_sel_arb.sv
// Bench for mux21_sel_arb: a vector table followed by multi-cycle sequences.
// One instance uses MAX_HOLD=8 and a second uses MAX_HOLD=1.
module tb_mux21_sel_arb;

  logic clk;
  logic rst;
  logic rst1;

  mux21_sel_arb_if bus8();
  mux21_sel_arb_if bus1();

  mux21_sel_arb #(.MAX_HOLD(8), .HOLD_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  mux21_sel_arb #(.MAX_HOLD(1), .HOLD_W(8)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Encoded as {gnt_a, gnt_b, s, busy}
  localparam logic [3:0] E_IDLE0 = 4'b0000;
  localparam logic [3:0] E_IDLE1 = 4'b0010;
  localparam logic [3:0] E_A     = 4'b1001;
  localparam logic [3:0] E_B     = 4'b0111;

  typedef struct {
    logic       rst;
    logic       ra;
    logic       rb;
    logic       la;
    logic       lb;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[17];
  logic [3:0] sb[$];
  int         n_total;
  int         n_pass;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got {ga,gb,s,busy}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic step8(input logic r, input logic ra, input logic rb,
                       input logic la, input logic lb, input logic [3:0] e,
                       input string name);
    logic [3:0] want;
    rst         = r;
    bus8.req_a  = ra;
    bus8.req_b  = rb;
    bus8.last_a = la;
    bus8.last_b = lb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    check(name, {bus8.gnt_a, bus8.gnt_b, bus8.s, bus8.busy}, want);
  endtask

  task automatic step1(input logic r, input logic ra, input logic rb,
                       input logic [3:0] e, input string name);
    logic [3:0] want;
    rst1        = r;
    bus1.req_a  = ra;
    bus1.req_b  = rb;
    bus1.last_a = 1'b0;
    bus1.last_b = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    want = sb.pop_front();
    check(name, {bus1.gnt_a, bus1.gnt_b, bus1.s, bus1.busy}, want);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst  = 1'b1;
    rst1 = 1'b1;
    bus8.req_a = 1'b0; bus8.req_b = 1'b0; bus8.last_a = 1'b0; bus8.last_b = 1'b0;
    bus1.req_a = 1'b0; bus1.req_b = 1'b0; bus1.last_a = 1'b0; bus1.last_b = 1'b0;

    //          rst   ra    rb    la    lb    expected after the edge
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_A};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, E_IDLE0};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_B};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, E_A};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, E_B};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_A};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_A};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_IDLE0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_B};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_B};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_A};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_IDLE0};

    for (int i = 0; i < 17; i++) begin
      step8(vecs[i].rst, vecs[i].ra, vecs[i].rb, vecs[i].la, vecs[i].lb,
            vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Single packet of five beats from A, last on the fifth
    for (int k = 0; k < 5; k++) begin
      step8(1'b0, 1'b1, 1'b0, (k == 4), 1'b0, (k == 4) ? E_IDLE0 : E_A,
            $sformatf("pkt%0d", k));
    end

    // A was served last, so B wins first; then 8-cycle alternating blocks
    for (int j = 0; j < 32; j++) begin
      step8(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (((j / 8) % 2) == 0) ? E_B : E_A,
            $sformatf("preempt%0d", j));
    end
    step8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE0, "preempt_drop");

    // Sole requester keeps the grant; saturated counter preempts at once when A joins
    for (int j = 0; j < 300; j++) begin
      step8(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, E_B, $sformatf("sole%0d", j));
    end
    step8(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_A, "sat_preempt");
    step8(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, E_IDLE0, "rst_mid_grant");

    // MAX_HOLD=1 alternates every cycle under continuous contention
    step1(1'b1, 1'b1, 1'b1, E_IDLE0, "h1_reset");
    for (int j = 0; j < 6; j++) begin
      step1(1'b0, 1'b1, 1'b1, ((j % 2) == 0) ? E_A : E_B, $sformatf("h1_alt%0d", j));
    end

    rst  = 1'b1;
    rst1 = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
